csr_host_driver: RTL
====================

CSR_HOST_DRIVER -- requirements
Module: csr_host_driver

Interface
REQ-001 Parameter ROWS, 3, number of matrix rows and result words.
REQ-002 Parameter COLS, 3, number of matrix columns and spike bits.
REQ-003 Parameter VW, 8, value and result width in bits.
REQ-004 Port clk  in  1  single system clock, rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port mat_wr  in  1  write strobe for local dense matrix.
REQ-007 Port mat_addr  in  4  entry index, row*COLS+col.
REQ-008 Port mat_data  in  VW  entry value.
REQ-009 Port spikes  in  COLS  spike vector, sampled on accepted go.
REQ-010 Port go  in  1  start one transaction.
REQ-011 Port busy  out  1  transaction in progress.
REQ-012 Port done  out  1  one-cycle pulse when all results have been captured.
REQ-013 Port result  out  ROWS*VW  packed results, row 0 in the LSBs.
REQ-014 Port nnz  out  4  number of CSR entries sent in the last transaction.
REQ-015 Port acc_start / acc_sending / acc_done_list  out  1 each  accelerator start, data strobe, end-of-list.
REQ-016 Port acc_row / acc_col  out  2 each  entry row and column index; acc_value  out  VW  entry value or spike vector (bits [COLS-1:0]).
REQ-017 Port acc_fetch_ready / acc_sending_out  in  1 each; acc_output_val  in  VW  accelerator result word.

Function
REQ-018 States: IDLE, START, SCAN, SEND, GAP, LIST_END, TRAIN, CAPTURE, FINISH.
REQ-019 In IDLE, mat_wr writes the matrix store, with a write to mat_addr >= ROWS*COLS ignored; go=1 samples spikes, clears nnz, and moves to START; mat_wr and go are ignored while busy=1.
REQ-020 START holds acc_start=1 until acc_fetch_ready=1 is seen, then drops acc_start and moves to SCAN.
REQ-021 SCAN walks entries in row-major order, skips zeros, presents the next nonzero entry on acc_row/acc_col/acc_value, and goes to SEND; when the scan is exhausted it goes to LIST_END.
REQ-022 An all-zero matrix sends exactly one entry (row 0, col 0, value 0), so nnz=1.
REQ-023 SEND asserts acc_sending for exactly one cycle, only in a cycle where acc_fetch_ready=1, increments nnz, then moves to GAP.
REQ-024 GAP waits until acc_fetch_ready=0 is seen, then returns to SCAN; acc_sending is never asserted in consecutive cycles.
REQ-025 LIST_END, once acc_fetch_ready=1, pulses acc_done_list for one cycle, then waits for acc_fetch_ready 0 then 1 and moves to TRAIN.
REQ-026 TRAIN drives acc_value={zeros,spikes}, pulses acc_sending for one cycle, latches acc_sending_out as prev_tog, and moves to CAPTURE.
REQ-027 CAPTURE detects a toggle when acc_sending_out != prev_tog and updates prev_tog each cycle.
REQ-028 In CAPTURE, the first toggle is a header and is discarded; toggles 2..ROWS+1 store acc_output_val, sampled in the same cycle, into result rows 0..ROWS-1.
REQ-029 In CAPTURE, any further toggles are ignored.
REQ-030 After the last result is stored, FINISH pulses done for one cycle and returns to IDLE.
REQ-031 result updates only in CAPTURE and holds otherwise.
REQ-032 busy=1 in every state except IDLE.
REQ-033 acc_sending and acc_done_list are never both 1.

Reset
REQ-034 On rst_n=0, immediately: state=IDLE; busy, done, acc_start, acc_sending, acc_done_list = 0; acc_row, acc_col, acc_value, nnz, result = 0; matrix store cleared to zero.
REQ-035 Reset mid-transaction abandons it, and no done pulse is issued.

Configuration
REQ-036 Macro CSR_HOST_TIMEOUT_EN defined adds an 8-bit watchdog that clears on any handshake progress; at 255 idle cycles outside IDLE it forces IDLE, pulses done, and sets output err (1 bit, sticky until the next accepted go).
REQ-037 Without CSR_HOST_TIMEOUT_EN there is no watchdog and no err port, and the block waits indefinitely.

Structure
REQ-038 Package csr_host_pkg holds the state enum, ROWS/COLS/VW defaults, and MAX_NNZ=ROWS*COLS.
REQ-039 Sub-module csr_nz_scan is combinational: given the current index and matrix, it returns the next nonzero index and a valid flag.

Verification
REQ-040 Matrix [[5,0,0],[0,7,0],[0,0,9]], spikes=3'b101, accelerator model -> 3 entries (0,0,5),(1,1,7),(2,2,9); nnz=3; result rows = 5,0,9; one done pulse.
REQ-041 All-zero matrix, spikes=3'b111 -> single entry (0,0,0), nnz=1, result all 0.
REQ-042 Dense matrix of all 1s, spikes=3'b111 -> 9 entries, never two consecutive acc_sending cycles, result rows = 3,3,3.
REQ-043 Assert rst_n=0 during GAP after the 2nd entry -> all outputs 0 immediately, no done pulse; a following go completes normally.
REQ-044 go and mat_wr issued while busy -> ignored, and the matrix store is unchanged.
REQ-045 With CSR_HOST_TIMEOUT_EN, a model that holds acc_fetch_ready=0 -> done and err assert 255 cycles after the last progress.

Source files
------------

// File: rtl/csr_host_pkg.sv
// Shared types and default sizing for the CSR host driver.
// No logic; constants and the controller state encoding only.
// No flow control of its own.
package csr_host_pkg;

    localparam int DEF_ROWS = 3;
    localparam int DEF_COLS = 3;
    localparam int DEF_VW   = 8;
    localparam int MAX_NNZ  = DEF_ROWS * DEF_COLS;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_SCAN,
        S_SEND,
        S_GAP,
        S_LIST_END,
        S_TRAIN,
        S_CAPTURE,
        S_FINISH
    } state_t;

endpackage

// File: rtl/csr_nz_scan.sv
// Finds the first nonzero matrix entry at or after cur_idx, row-major order.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to consume the result.
module csr_nz_scan
    import csr_host_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int VW   = DEF_VW
)(
    input  logic [3:0]              cur_idx,
    input  logic [ROWS*COLS*VW-1:0] mat_flat,
    output logic [3:0]              nxt_idx,
    output logic [1:0]              nxt_row,
    output logic [1:0]              nxt_col,
    output logic [VW-1:0]           nxt_val,
    output logic                    nxt_vld
);

    localparam int N = ROWS * COLS;

    // Walk from the top index down so the lowest qualifying index is the last write and wins
    always_comb begin
        nxt_idx = '0;
        nxt_row = '0;
        nxt_col = '0;
        nxt_val = '0;
        nxt_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((4'(i) >= cur_idx) && (mat_flat[i*VW +: VW] != '0)) begin
                nxt_idx = 4'(i);
                nxt_row = 2'(i / COLS);
                nxt_col = 2'(i % COLS);
                nxt_val = mat_flat[i*VW +: VW];
                nxt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csr_host_driver.sv
// Streams a locally stored dense matrix to an accelerator as CSR entries, sends a spike train, captures results.
// Latency: one entry per scan/send/gap round trip; done one cycle after the last result word is captured.
// Backpressure: every send waits on acc_fetch_ready; optional watchdog (CSR_HOST_TIMEOUT_EN) aborts a stalled transaction.
module csr_host_driver
    import csr_host_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int VW   = DEF_VW
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mat_wr,
    input  logic [3:0]           mat_addr,
    input  logic [VW-1:0]        mat_data,
    input  logic [COLS-1:0]      spikes,
    input  logic                 go,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*VW-1:0]   result,
    output logic [3:0]           nnz,
    output logic                 acc_start,
    output logic                 acc_sending,
    output logic                 acc_done_list,
    output logic [1:0]           acc_row,
    output logic [1:0]           acc_col,
    output logic [VW-1:0]        acc_value,
    input  logic                 acc_fetch_ready,
    input  logic                 acc_sending_out,
    input  logic [VW-1:0]        acc_output_val
`ifdef CSR_HOST_TIMEOUT_EN
    ,
    output logic                 err
`endif
);

    localparam int N = ROWS * COLS;

    state_t          state, state_d;
    logic [VW-1:0]   mat_q [N];
    logic [N*VW-1:0] mat_flat;
    logic [3:0]      idx_q;       // next index the scan starts from
    logic [COLS-1:0] spk_q;
    logic [1:0]      lp_q;        // list-end phase: 0 await ready, 1 await low, 2 await high
    logic [3:0]      cap_q;       // result toggles seen so far, header included
    logic            prev_tog;
    logic            toggle;
    logic            timeout;

    logic [3:0]      scan_idx;
    logic [1:0]      scan_row;
    logic [1:0]      scan_col;
    logic [VW-1:0]   scan_val;
    logic            scan_vld;

    csr_nz_scan #(.ROWS(ROWS), .COLS(COLS), .VW(VW)) u_scan (
        .cur_idx  (idx_q),
        .mat_flat (mat_flat),
        .nxt_idx  (scan_idx),
        .nxt_row  (scan_row),
        .nxt_col  (scan_col),
        .nxt_val  (scan_val),
        .nxt_vld  (scan_vld)
    );

    assign toggle = (acc_sending_out != prev_tog);
    assign busy   = (state != S_IDLE);

    // Flatten the matrix store for the scanner
    always_comb begin
        mat_flat = '0;
        for (int i = 0; i < N; i++) begin
            mat_flat[i*VW +: VW] = mat_q[i];
        end
    end

`ifdef CSR_HOST_TIMEOUT_EN
    logic [7:0] wd_q;
    logic       progress;

    assign timeout  = (state != S_IDLE) && (wd_q == 8'hFF);
    assign progress = (state_d != state) || acc_done_list
                    || ((state == S_LIST_END) && (lp_q == 2'd1) && !acc_fetch_ready)
                    || ((state == S_CAPTURE) && toggle);

    // Watchdog counts stalled cycles and restarts on any handshake movement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           wd_q <= '0;
        else if ((state == S_IDLE) || progress) wd_q <= '0;
        else if (wd_q != 8'hFF)               wd_q <= wd_q + 8'd1;
    end

    // Error flag survives until the next transaction is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      err <= 1'b0;
        else if ((state == S_IDLE) && go) err <= 1'b0;
        else if (timeout)                err <= 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state and handshake strobes
    always_comb begin
        state_d       = state;
        acc_start     = 1'b0;
        acc_sending   = 1'b0;
        acc_done_list = 1'b0;
        done          = 1'b0;
        case (state)
            S_IDLE:     if (go) state_d = S_START;
            S_START: begin
                acc_start = 1'b1;
                if (acc_fetch_ready) state_d = S_SCAN;
            end
            // An empty matrix still sends one zero entry so the list is never empty
            S_SCAN:     state_d = (scan_vld || (nnz == '0)) ? S_SEND : S_LIST_END;
            S_SEND: begin
                if (acc_fetch_ready) begin
                    acc_sending = 1'b1;
                    state_d     = S_GAP;
                end
            end
            S_GAP:      if (!acc_fetch_ready) state_d = S_SCAN;
            S_LIST_END: begin
                if ((lp_q == 2'd0) && acc_fetch_ready) acc_done_list = 1'b1;
                if ((lp_q == 2'd2) && acc_fetch_ready) state_d = S_TRAIN;
            end
            S_TRAIN: begin
                acc_sending = 1'b1;
                state_d     = S_CAPTURE;
            end
            S_CAPTURE:  if (toggle && (cap_q == 4'(ROWS))) state_d = S_FINISH;
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
        if (timeout) begin
            state_d       = S_IDLE;
            done          = 1'b1;
            acc_start     = 1'b0;
            acc_sending   = 1'b0;
            acc_done_list = 1'b0;
        end
    end

    // Matrix store, scan pointer, entry presentation and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mat_q[i] <= '0;
            idx_q     <= '0;
            spk_q     <= '0;
            lp_q      <= '0;
            cap_q     <= '0;
            prev_tog  <= 1'b0;
            nnz       <= '0;
            result    <= '0;
            acc_row   <= '0;
            acc_col   <= '0;
            acc_value <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mat_wr && (mat_addr < 4'(N))) mat_q[mat_addr] <= mat_data;
                    if (go) begin
                        spk_q <= spikes;
                        nnz   <= '0;
                        idx_q <= '0;
                        lp_q  <= '0;
                        cap_q <= '0;
                    end
                end
                S_SCAN: begin
                    if (scan_vld) begin
                        acc_row   <= scan_row;
                        acc_col   <= scan_col;
                        acc_value <= scan_val;
                        idx_q     <= scan_idx + 4'd1;
                    end else if (nnz == '0) begin
                        acc_row   <= '0;
                        acc_col   <= '0;
                        acc_value <= '0;
                        idx_q     <= 4'(N);
                    end
                end
                S_SEND:     if (acc_fetch_ready) nnz <= nnz + 4'd1;
                S_LIST_END: begin
                    case (lp_q)
                        2'd0:    if (acc_fetch_ready)  lp_q <= 2'd1;
                        2'd1:    if (!acc_fetch_ready) lp_q <= 2'd2;
                        2'd2:    if (acc_fetch_ready)  acc_value <= {{(VW-COLS){1'b0}}, spk_q};
                        default: lp_q <= 2'd0;
                    endcase
                end
                S_TRAIN:    prev_tog <= acc_sending_out;
                S_CAPTURE: begin
                    prev_tog <= acc_sending_out;
                    if (toggle) begin
                        // First toggle is the header; later toggles beyond ROWS are dropped
                        if ((cap_q != 4'd0) && (cap_q <= 4'(ROWS)))
                            result[(int'(cap_q) - 1)*VW +: VW] <= acc_output_val;
                        if (cap_q != 4'hF) cap_q <= cap_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
